// File: rtl/alu_pkg.sv
// Shared opcode/state encodings and small decode helpers for the iterative ALU.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_RAND   = 5'd5,
    OP_ROR    = 5'd6,
    OP_RXOR   = 5'd7,
    OP_SHL    = 5'd8,
    OP_SHR    = 5'd9,
    OP_RSV17  = 5'd17,
    OP_PASS   = 5'd18,
    OP_RSV19  = 5'd19,
    OP_RSV20  = 5'd20,
    OP_SLT    = 5'd21,
    OP_RSV22  = 5'd22,
    OP_RSV23  = 5'd23,
    OP_RSV24  = 5'd24,
    OP_MUL    = 5'd25,
    OP_MULH   = 5'd26,
    OP_DONE   = 5'd31
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_shift(input logic [4:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

  function automatic logic is_mul(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_MULH);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle datapath: arithmetic, bitwise and reduction ops on the raw operands.
module alu_comb
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [4:0]   opcode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] res,
  output logic         carry
);

  logic [W:0] sum_s;
  logic [W:0] diff_s;

  // Select the single-cycle result; unknown opcodes (and shifts/muls) pass a through.
  always_comb begin
    sum_s  = {1'b0, a} + {1'b0, b};
    diff_s = {1'b0, a} - {1'b0, b};
    res    = a;
    carry  = 1'b0;
    case (opcode)
      OP_ADD:  begin res = sum_s[W-1:0];  carry = sum_s[W];  end
      OP_SUB:  begin res = diff_s[W-1:0]; carry = diff_s[W]; end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_RAND: res = {{(W-1){1'b0}}, (&a) & (&b)};
      OP_ROR:  res = {{(W-1){1'b0}}, (|a) | (|b)};
      OP_RXOR: res = {{(W-1){1'b0}}, (^a) ^ (^b)};
      OP_PASS: res = b;
      OP_SLT:  res = {{(W-1){1'b0}}, (a < b)};
      default: begin res = a; carry = 1'b0; end
    endcase
  end

endmodule

// File: rtl/alu_iter.sv
// Registered accumulator ALU: one-cycle logic ops, bit-serial shifts and a
// shift-add multiplier, sequenced by an IDLE/RUN/DONE controller.
module alu_iter
  import alu_pkg::*;
#(
  parameter int W   = 8,
  parameter int SHW = $clog2(W)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [4:0]   opcode,
  input  logic [W-1:0] acc_in,
  input  logic [W-1:0] val_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         carry,
  output logic         neg
);

  localparam logic [1:0]   IDLE    = ST_IDLE;
  localparam logic [1:0]   RUN     = ST_RUN;
  localparam logic [1:0]   DONE    = ST_DONE;
  localparam logic [SHW:0] W_CNT   = (SHW+1)'(W);
  localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);

  logic [1:0]     state_r;
  logic [SHW:0]   cnt_r;
  logic [4:0]     op_r;
  logic [W-1:0]   work_r;
  logic [W-1:0]   mcand_r;
  logic [2*W-1:0] prod_r;
  logic [W-1:0]   result_r;
  logic           zero_r, carry_r, neg_r, busy_r, done_r;

  logic [W-1:0]   comb_res_s;
  logic           comb_carry_s;
  logic [SHW:0]   n_s;
  logic           accept_s;
  logic           go_run_s;
  logic [W:0]     psum_s;
  logic [2*W-1:0] prod_nx_s;
  logic [W-1:0]   work_nx_s;
  logic           shift_out_s;
  logic [W-1:0]   run_res_s;
  logic           run_carry_s;

  alu_comb #(.W(W)) u_comb (
    .opcode (opcode),
    .a      (acc_in),
    .b      (val_in),
    .res    (comb_res_s),
    .carry  (comb_carry_s)
  );

  // Start decode plus one iteration step of the shifter and the multiplier.
  always_comb begin
    n_s      = (val_in[SHW:0] > W_CNT) ? W_CNT : val_in[SHW:0];
    accept_s = start && (state_r != RUN);
    go_run_s = (is_shift(opcode) && (n_s != {(SHW+1){1'b0}})) || is_mul(opcode);
    // Multiplier in prod_r low half is consumed LSB-first as partial sums enter the top.
    psum_s    = {1'b0, prod_r[2*W-1:W]} + (prod_r[0] ? {1'b0, mcand_r} : {(W+1){1'b0}});
    prod_nx_s = {psum_s, prod_r[W-1:1]};
    if (op_r == OP_SHL) begin
      work_nx_s   = {work_r[W-2:0], 1'b0};
      shift_out_s = work_r[W-1];
    end else begin
      work_nx_s   = {1'b0, work_r[W-1:1]};
      shift_out_s = work_r[0];
    end
    if (op_r == OP_MUL) begin
      run_res_s   = prod_nx_s[W-1:0];
      run_carry_s = |prod_nx_s[2*W-1:W];
    end else if (op_r == OP_MULH) begin
      run_res_s   = prod_nx_s[2*W-1:W];
      run_carry_s = |prod_nx_s[W-1:0];
    end else begin
      run_res_s   = work_nx_s;
      run_carry_s = shift_out_s;
    end
  end

  // Controller, iteration registers and registered result/flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= {(SHW+1){1'b0}};
      op_r     <= 5'd0;
      work_r   <= {W{1'b0}};
      mcand_r  <= {W{1'b0}};
      prod_r   <= {(2*W){1'b0}};
      result_r <= {W{1'b0}};
      zero_r   <= 1'b0;
      carry_r  <= 1'b0;
      neg_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          cnt_r  <= cnt_r - CNT_ONE;
          work_r <= work_nx_s;
          prod_r <= prod_nx_s;
          if (cnt_r == CNT_ONE) begin
            state_r  <= DONE;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            result_r <= run_res_s;
            carry_r  <= run_carry_s;
            zero_r   <= (run_res_s == {W{1'b0}});
            neg_r    <= run_res_s[W-1];
          end else begin
            done_r <= 1'b0;
          end
        end
        IDLE, DONE: begin
          if (accept_s) begin
            op_r    <= opcode;
            work_r  <= acc_in;
            mcand_r <= val_in;
            prod_r  <= {{W{1'b0}}, acc_in};
            if (go_run_s) begin
              state_r <= RUN;
              busy_r  <= 1'b1;
              done_r  <= 1'b0;
              cnt_r   <= is_mul(opcode) ? W_CNT : n_s;
            end else begin
              state_r  <= DONE;
              done_r   <= 1'b1;
              result_r <= comb_res_s;
              carry_r  <= comb_carry_s;
              zero_r   <= (comb_res_s == {W{1'b0}});
              neg_r    <= comb_res_s[W-1];
            end
          end else begin
            state_r <= IDLE;
            done_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
  assign zero   = zero_r;
  assign carry  = carry_r;
  assign neg    = neg_r;

endmodule

// File: doc/alu_iter.md
# alu_iter

Parametrised, registered successor to the processor's accumulator ALU. It takes an accumulator operand and a value operand plus a 5-bit opcode on a start strobe. It returns a registered result and zero/carry/negative flags with a one-cycle done pulse. Logic ops complete in one cycle; shifts iterate one bit per cycle; a new shift-add multiplier produces low or high halves. It sits between the register file/accumulator and the writeback mux; the controller stalls on busy.

## Interface
- W, 8: operand/result width; W ≥ 4, power of two.
- SHW, $clog2(W): shift-count index; count field is val_in[SHW:0].
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  operation request; accepted when state is IDLE or DONE.
- opcode  in  5  operation select, sampled on accepted start.
- acc_in  in  W  accumulator operand, sampled on accepted start.
- val_in  in  W  value operand, sampled on accepted start.
- busy  out  1  high exactly while state is RUN.
- done  out  1  one-cycle pulse: result/flags valid.
- result  out  W  registered result; holds until the next done.
- zero, carry, neg  out  1 each  registered flags; hold with result.

## Operation
- States: IDLE, RUN, DONE.
- Start acceptance:
  - start is accepted in IDLE or DONE; ignored in RUN.
  - Operands and opcode are latched on an accepted start; later input changes have no effect.
- Single-cycle ops (accepted start → DONE):
  - 0 add, 1 sub, 2 and, 3 or, 4 xor.
  - 5 &acc & &val, 6 |acc | |val, 7 ^acc ^ ^val (zero-extended to W).
  - 18 pass val_in, 21 unsigned slt (0/1).
  - Any other opcode: result = acc_in, carry = 0.
- Multi-cycle ops (accepted start → RUN):
  - 8 shl, 9 shr (logical): n = min(val_in[SHW:0], W). One bit per RUN cycle, n RUN cycles. n = 0 goes straight to DONE with result = acc_in.
  - 25 mul: low W bits of acc × val, unsigned shift-add. Exactly W RUN cycles.
  - 26 mulh: high W bits of the same product.
- RUN decrements a (SHW+1)-bit counter and goes to DONE when the counter reaches 0.
- DONE lasts one cycle, then returns to IDLE unless a new start is accepted.
- Flag rules:
  - zero = (result == 0); neg = result[W-1].
  - carry by op:
    - add: carry-out.
    - sub: borrow (acc < val).
    - shl/shr: last bit shifted out; 0 when n = 0.
    - mul: high half ≠ 0.
    - mulh: low half ≠ 0.
    - all other ops: 0.

## Timing
- Accepted start in cycle 0:
  - single-cycle ops: done in cycle 1;
  - shifts: done in cycle n+1;
  - mul/mulh: done in cycle W+1.
- Back-to-back: a start during DONE is accepted, so single-cycle ops sustain one result per cycle (done high on consecutive cycles).
- busy never overlaps done.
- Reset values:
  - state IDLE;
  - result 0; zero, carry, neg 0;
  - busy 0, done 0.
- Reset during RUN aborts the operation: no done pulse, outputs return to their reset values immediately.

## Structure
- Shared package alu_pkg:
  - opcode enum (all values above, including reserved 17, 19, 20, 22–24 and 31 = done);
  - state enum.
- Sub-module alu_comb: combinational single-cycle datapath (W-parameterised), returning result and carry.
- alu_iter contains the FSM, counter, shift/multiply registers and the flag logic.

## Test plan
- W=8, add acc=0xFF, val=0x01 → cycle 1: done=1, result=0x00, zero=1, carry=1, neg=0.
- shl acc=0x81, val=3 → busy for cycles 1–3, done at cycle 4, result=0x08, carry=0. Then shr acc=0x81, val=1 → done at cycle 2, result=0x40, carry=1.
- mul acc=0x10, val=0x20 → done at cycle 9, result=0x00, zero=1, carry=1. mulh with the same operands → result=0x02, carry=0.
- shl acc=0xFF, val=12 (count saturates to 8) → done at cycle 9, result=0x00, carry=1.
- Back-to-back starts, with start held high in cycles 0 and 1:
  - add 2+3 in cycle 0, then slt 2<3 in cycle 1 → done in cycles 1 and 2; results 0x05 then 0x01.
  - opcode 30 → result = acc_in.
- start during RUN is ignored. Reset asserted at cycle 3 of a mul → no done pulse, result=0 and busy=0 while reset is asserted; the next mul completes normally.
